// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - multi-phase countdown engine with prescaled tick; optional running total under PHASE_TIMER_TOTAL_EN
module phase_timer #(
  parameter int NUM_PHASES = 8,
  parameter int PHASE_W    = 4,
  parameter int TICK_DIV   = 5000,
  localparam int IDX_W     = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
  localparam int SUM_W     = PHASE_W + $clog2(NUM_PHASES + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic                          start,
  input  logic                          pause,
  input  logic                          abort,
  input  logic [NUM_PHASES*PHASE_W-1:0] durations,
  output logic [NUM_PHASES*PHASE_W-1:0] remain,
  output logic [IDX_W-1:0]              phase_idx,
  output logic [2:0]                    state,
  output logic                          tick,
  output logic                          phase_done,
  output logic                          finished,
  output logic [SUM_W-1:0]              total_remain
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] TERM = PRE_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOADED = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                          state_q, state_d;
  logic [NUM_PHASES*PHASE_W-1:0]   remain_q, remain_d;
  logic [PRE_W-1:0]                presc_q, presc_d;
  logic                            tick_q, tick_d;
  logic                            phase_done_q, phase_done_d;
  logic [IDX_W-1:0]                idx;
  logic [PHASE_W-1:0]              fld;
  logic                            terminal;

  // Active phase is the highest-index nonzero field; zero fields are skipped
  always_comb begin
    idx = '0;
    for (int k = 0; k < NUM_PHASES; k++) begin
      if (remain_q[k*PHASE_W +: PHASE_W] != '0) idx = IDX_W'(k);
    end
  end

  // Command decode (abort > load > start > pause) and prescaled countdown
  always_comb begin
    state_d      = state_q;
    remain_d     = remain_q;
    presc_d      = presc_q;
    tick_d       = 1'b0;
    phase_done_d = 1'b0;
    fld          = '0;
    terminal     = (state_q == S_RUN) && (presc_q == TERM);
    if (abort) begin
      state_d  = S_IDLE;
      remain_d = '0;
      presc_d  = '0;
    end else if (load) begin
      // In RUN/PAUSE the load is ignored, but it still owns the cycle: nothing advances
      if (state_q == S_IDLE || state_q == S_LOADED || state_q == S_DONE) begin
        state_d  = S_LOADED;
        remain_d = durations;
        presc_d  = '0;
      end
    end else if (start && (state_q == S_LOADED || state_q == S_PAUSE)) begin
      // The start edge itself does not advance the prescaler
      if (remain_q == '0) begin
        state_d = S_DONE;
        presc_d = '0;
      end else begin
        state_d = S_RUN;
      end
    end else if (state_q == S_RUN) begin
      if (pause) state_d = S_PAUSE;
      if (terminal) begin
        tick_d  = 1'b1;
        presc_d = '0;
        for (int k = 0; k < NUM_PHASES; k++) begin
          if (IDX_W'(k) == idx) fld = remain_q[k*PHASE_W +: PHASE_W];
        end
        if (fld != '0) begin
          for (int k = 0; k < NUM_PHASES; k++) begin
            if (IDX_W'(k) == idx) remain_d[k*PHASE_W +: PHASE_W] = fld - PHASE_W'(1);
          end
          if (fld == PHASE_W'(1)) phase_done_d = 1'b1;
        end
        if (remain_d == '0) state_d = S_DONE;
      end else if (!pause) begin
        presc_d = presc_q + PRE_W'(1);
      end
    end
  end

  // Core state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      remain_q     <= '0;
      presc_q      <= '0;
      tick_q       <= 1'b0;
      phase_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      remain_q     <= remain_d;
      presc_q      <= presc_d;
      tick_q       <= tick_d;
      phase_done_q <= phase_done_d;
    end
  end

`ifdef PHASE_TIMER_TOTAL_EN
  logic [SUM_W-1:0] total_q, total_d, dur_sum;
  logic             load_ok;

  // Running total: reloaded with the sum of durations, stepped down once per tick
  always_comb begin
    dur_sum = '0;
    for (int k = 0; k < NUM_PHASES; k++) begin
      dur_sum = dur_sum + SUM_W'(durations[k*PHASE_W +: PHASE_W]);
    end
    load_ok = !abort && load && (state_q != S_RUN) && (state_q != S_PAUSE);
    total_d = total_q;
    if (abort)                         total_d = '0;
    else if (load_ok)                  total_d = dur_sum;
    else if (tick_d && total_q != '0)  total_d = total_q - SUM_W'(1);
  end

  // Total register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) total_q <= '0;
    else        total_q <= total_d;
  end

  assign total_remain = total_q;
`else
  assign total_remain = '0;
`endif

  assign remain     = remain_q;
  assign phase_idx  = idx;
  assign state      = state_q;
  assign tick       = tick_q;
  assign phase_done = phase_done_q;
  assign finished   = (state_q == S_DONE);

endmodule
